// File: rtl/mem_line_pkg.sv
// Shared types and constants for the line-organised memory responder.
package mem_line_pkg;

  localparam int LINE_W = 128;
  localparam int OFS_W  = 4;
  localparam int WORD_W = 32;
  localparam int WORDS  = LINE_W / WORD_W;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} mem_state_e;

  typedef struct packed {
    logic [2:0]        mtype;
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [LINE_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/mem_line_word_merge.sv
// Splices one 32-bit word into a 128-bit line, and picks the same word back out.
module mem_line_word_merge
  import mem_line_pkg::*;
(
  input  logic [LINE_W-1:0] line_in,
  input  logic [WORD_W-1:0] word_in,
  input  logic [1:0]        word_sel,
  output logic [LINE_W-1:0] line_out,
  output logic [WORD_W-1:0] word_out
);

  logic [WORDS-1:0][WORD_W-1:0] words;
  logic [WORDS-1:0][WORD_W-1:0] merged;

  assign words = line_in;

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign merged[w] = (word_sel == 2'(w)) ? word_in : words[w];
  end

  assign line_out = merged;
  assign word_out = words[word_sel];

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side val/rdy responder with a line array and fixed response latency.
// Optional MEM_LINE_RESPONDER_RAND_DELAY_EN adds 0-3 LFSR-driven wait cycles.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int p_num_lines = 64,
  parameter int p_latency   = 2,
  parameter int p_opq_nbits = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memreq_val,
  output logic                   memreq_rdy,
  input  logic [2:0]             memreq_type,
  input  logic [p_opq_nbits-1:0] memreq_opaque,
  input  logic [31:0]            memreq_addr,
  input  logic [3:0]             memreq_len,
  input  logic [LINE_W-1:0]      memreq_data,
  output logic                   memresp_val,
  input  logic                   memresp_rdy,
  output logic [2:0]             memresp_type,
  output logic [p_opq_nbits-1:0] memresp_opaque,
  output logic [3:0]             memresp_len,
  output logic [LINE_W-1:0]      memresp_data
);

  localparam int IDX_W = $clog2(p_num_lines);
  localparam int CNT_W = $clog2(p_latency + 5);

  mem_state_e state, state_nxt;
  mem_req_t   in_req, req_q, act;

  logic [p_opq_nbits-1:0] opq_q, act_opq;
  logic [CNT_W-1:0]       cnt_q, wait_total;
  logic [LINE_W-1:0]      mem [p_num_lines];

  logic              accept, resp_enter;
  logic              act_wr, act_word;
  logic [IDX_W-1:0]  act_idx;
  logic [LINE_W-1:0] cur_line, merged_line;
  logic [WORD_W-1:0] sel_word;

  logic [2:0]             rsp_type_q;
  logic [p_opq_nbits-1:0] rsp_opq_q;
  logic [3:0]             rsp_len_q;
  logic [LINE_W-1:0]      rsp_data_q;

  assign in_req = {memreq_type, memreq_addr, memreq_len, memreq_data};

  // With zero wait the array action happens on the accept edge itself,
  // so the live request is used before it lands in req_q.
  assign act     = (state == ST_IDLE) ? in_req : req_q;
  assign act_opq = (state == ST_IDLE) ? memreq_opaque : opq_q;

  assign act_wr   = (act.mtype == MEM_TYPE_WRITE) || (act.mtype == MEM_TYPE_INIT);
  assign act_word = (act.len != 4'd0);
  assign act_idx  = act.addr[OFS_W +: IDX_W];
  assign cur_line = mem[act_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{act.addr[31:OFS_W+IDX_W], act.addr[1:0]};

`ifdef MEM_LINE_RESPONDER_RAND_DELAY_EN
  // x^7+x^6+1; the current low bits set this request's extra wait, then it steps.
  logic [6:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (reset)       lfsr_q <= 7'h5A;
    else if (accept) lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end
  assign wait_total = CNT_W'(p_latency) + CNT_W'(lfsr_q[1:0]);
`else
  assign wait_total = CNT_W'(p_latency);
`endif

  mem_line_word_merge u_merge (
    .line_in  (cur_line),
    .word_in  (act.data[WORD_W-1:0]),
    .word_sel (act.addr[3:2]),
    .line_out (merged_line),
    .word_out (sel_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    accept      = 1'b0;
    resp_enter  = 1'b0;
    case (state)
      ST_IDLE: begin
        memreq_rdy = !reset;
        if (memreq_val && !reset) begin
          accept = 1'b1;
          if (wait_total != '0) state_nxt = ST_WAIT;
          else begin
            state_nxt  = ST_RESP;
            resp_enter = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_nxt  = ST_RESP;
          resp_enter = !reset;
        end
      end
      ST_RESP: begin
        memresp_val = !reset;
        if (memresp_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                          cnt_q <= '0;
    else if (accept && wait_total != '0) cnt_q <= wait_total - 1'b1;
    else if (state == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= in_req;
      opq_q <= memreq_opaque;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_enter && act_wr)
      mem[act_idx] <= act_word ? merged_line : act.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_type_q <= '0;
      rsp_opq_q  <= '0;
      rsp_len_q  <= '0;
      rsp_data_q <= '0;
    end else if (resp_enter) begin
      rsp_type_q <= act.mtype;
      rsp_opq_q  <= act_opq;
      rsp_len_q  <= act.len;
      if (act_wr)        rsp_data_q <= '0;
      else if (act_word) rsp_data_q <= {{(LINE_W-WORD_W){1'b0}}, sel_word};
      else               rsp_data_q <= cur_line;
    end
  end

  assign memresp_type   = rsp_type_q;
  assign memresp_opaque = rsp_opq_q;
  assign memresp_len    = rsp_len_q;
  assign memresp_data   = rsp_data_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: line model, latency, backpressure, reset drop.
module tb_mem_line_responder;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_val, req_rdy, resp_val, resp_rdy;
  logic [2:0]   req_type, resp_type;
  logic [7:0]   req_opq, resp_opq;
  logic [31:0]  req_addr;
  logic [3:0]   req_len, resp_len;
  logic [127:0] req_data, resp_data;

  logic         val0, rdy0, rval0, rrdy0;
  logic [2:0]   type0, rtype0;
  logic [7:0]   opq0, ropq0;
  logic [31:0]  addr0;
  logic [3:0]   len0, rlen0;
  logic [127:0] data0, rdata0;

  always #5 clk = ~clk;

  mem_line_responder #(.p_num_lines(64), .p_latency(LAT), .p_opq_nbits(8)) u_dut (
    .clk(clk), .reset(reset),
    .memreq_val(req_val), .memreq_rdy(req_rdy), .memreq_type(req_type),
    .memreq_opaque(req_opq), .memreq_addr(req_addr), .memreq_len(req_len),
    .memreq_data(req_data),
    .memresp_val(resp_val), .memresp_rdy(resp_rdy), .memresp_type(resp_type),
    .memresp_opaque(resp_opq), .memresp_len(resp_len), .memresp_data(resp_data)
  );

  mem_line_responder #(.p_num_lines(64), .p_latency(0), .p_opq_nbits(8)) u_dut0 (
    .clk(clk), .reset(reset),
    .memreq_val(val0), .memreq_rdy(rdy0), .memreq_type(type0),
    .memreq_opaque(opq0), .memreq_addr(addr0), .memreq_len(len0),
    .memreq_data(data0),
    .memresp_val(rval0), .memresp_rdy(rrdy0), .memresp_type(rtype0),
    .memresp_opaque(ropq0), .memresp_len(rlen0), .memresp_data(rdata0)
  );

  typedef struct {
    logic [2:0]   t;
    logic [7:0]   opq;
    logic [3:0]   len;
    logic [127:0] data;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         q[$];
  logic [127:0] ref_mem [64];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           val_cycles = 0;
  bit           seen = 1'b0;
  logic [6:0]   m_lfsr = 7'h5A;

  localparam logic [127:0] L0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_access(input logic [2:0] t, input logic [31:0] a,
                                                input logic [3:0] l, input logic [127:0] d);
    int           idx;
    int           w;
    logic [127:0] line;
    idx  = int'(a[9:4]);
    w    = int'(a[3:2]);
    line = ref_mem[idx];
    if (t == 3'd1 || t == 3'd2) begin
      if (l == 4'd0) line = d;
      else           line[w*32 +: 32] = d[31:0];
      ref_mem[idx] = line;
      return 128'd0;
    end
    if (l == 4'd0) return line;
    return {96'd0, line[w*32 +: 32]};
  endfunction

  always @(negedge clk) begin
    if (resp_val) begin
      val_cycles++;
      if (q.size() == 0) chk("no_resp_expected", 128'(resp_val), 128'(0));
      else begin
        if (!seen) begin
          chk("latency", 128'(cyc - q[0].acc), 128'(q[0].lat));
          seen = 1'b1;
        end
        chk("resp_type", 128'(resp_type), 128'(q[0].t));
        chk("resp_opq",  128'(resp_opq),  128'(q[0].opq));
        chk("resp_len",  128'(resp_len),  128'(q[0].len));
        chk("resp_data", resp_data, q[0].data);
        chk("req_rdy_in_resp", 128'(req_rdy), 128'(0));
        if (resp_rdy) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                      input logic [3:0] l, input logic [127:0] d);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!req_rdy && n < 100) begin @(negedge clk); n++; end
    if (!req_rdy) begin
      chk("req_timeout", 128'(req_rdy), 128'(1));
      return;
    end
    req_val = 1'b1; req_type = t; req_opq = o; req_addr = a; req_len = l; req_data = d;
    e.t = t; e.opq = o; e.len = l; e.acc = cyc;
    e.data = model_access(t, a, l, d);
    e.lat = LAT + 1;
`ifdef MEM_LINE_RESPONDER_RAND_DELAY_EN
    e.lat = e.lat + int'(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`endif
    q.push_back(e);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("resp_timeout", 128'(q.size()), 128'(0));
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    int           vc0;
    logic [127:0] wd;
    reset = 1'b1;
    req_val = 1'b0; req_type = '0; req_opq = '0; req_addr = '0; req_len = '0; req_data = '0;
    resp_rdy = 1'b1;
    val0 = 1'b0; type0 = '0; opq0 = '0; addr0 = '0; len0 = '0; data0 = '0; rrdy0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy",  128'(req_rdy),  128'(0));
    chk("rst_resp_val", 128'(resp_val), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_data", resp_data, 128'd0);
    chk("rst_resp_type", 128'(resp_type), 128'(0));
    chk("rst_resp_opq",  128'(resp_opq),  128'(0));
    chk("idle_req_rdy",  128'(req_rdy),   128'(1));

    // init then read back
    send(3'd2, 8'h01, 32'h1000, 4'd0, L0);                     drain();
    send(3'd0, 8'h11, 32'h1000, 4'd0, '0);                     drain();
    // word writes (len 4 and odd len) then line / word reads
    send(3'd1, 8'h22, 32'h1008, 4'd4, 128'hDEADBEEF);          drain();
    send(3'd0, 8'h23, 32'h1000, 4'd0, '0);                     drain();
    send(3'd1, 8'h24, 32'h100C, 4'd7, {96'hFFFF_1111_2222_3333_4444_5555, 32'hCAFEF00D}); drain();
    send(3'd0, 8'h25, 32'h100E, 4'd4, '0);                     drain();
    send(3'd5, 8'h26, 32'h1000, 4'd0, '0);                     drain();
    // index wraps modulo 64 lines
    send(3'd1, 8'h30, 32'h0000_0010, 4'd0, 128'h5555_AAAA_0F0F_F0F0_1234_5678_9ABC_DEF0); drain();
    send(3'd0, 8'h31, 32'h0000_0410, 4'd0, '0);                drain();

    // backpressure: 5 stalled RESP cycles, handshake on the 6th
    resp_rdy = 1'b0;
    vc0 = val_cycles;
    send(3'd0, 8'h40, 32'h1000, 4'd0, '0);
    n = 0;
    while (!resp_val && n < 50) begin @(negedge clk); n++; end
    chk("bp_resp_seen", 128'(resp_val), 128'(1));
    repeat (4) @(negedge clk);
    @(posedge clk); #1 resp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_val_cycles", 128'(val_cycles - vc0), 128'(6));
    chk("bp_back_idle",  128'(req_rdy),  128'(1));
    chk("bp_val_clear",  128'(resp_val), 128'(0));
    drain();

    // reset while in WAIT drops the request
    send(3'd0, 8'h50, 32'h1000, 4'd0, '0);
    reset = 1'b1;
    q.delete();
    m_lfsr = 7'h5A;
    @(negedge clk);
    reset = 1'b0;
    vc0 = val_cycles;
    repeat (8) @(negedge clk);
    chk("drop_no_resp", 128'(val_cycles - vc0), 128'(0));
    send(3'd0, 8'h51, 32'h1000, 4'd0, '0);                     drain();

`ifdef MEM_LINE_RESPONDER_RAND_DELAY_EN
    for (int i = 0; i < 8; i++) begin
      send(3'd0, 8'h60 + 8'(i), 32'h1000, 4'd4, '0);
      drain();
    end
`else
    // zero latency: response the next cycle, accepts exactly two cycles apart
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l0_req_rdy", 128'(rdy0), 128'(1));
      wd = {4{32'hA5A5_0000 + 32'(i % 3)}};
      val0 = 1'b1; type0 = (i < 3) ? 3'd1 : 3'd0; opq0 = 8'h70 + 8'(i);
      addr0 = 32'(i % 3) << 4; len0 = 4'd0; data0 = (i < 3) ? wd : '0;
      @(negedge clk);
      chk("l0_resp_val", 128'(rval0), 128'(1));
      chk("l0_rdy_busy", 128'(rdy0),  128'(0));
      chk("l0_resp_opq", 128'(ropq0), 128'(8'h70 + 8'(i)));
      chk("l0_resp_type", 128'(rtype0), 128'((i < 3) ? 3'd1 : 3'd0));
      chk("l0_resp_data", rdata0, (i < 3) ? 128'd0 : wd);
    end
    @(negedge clk);
    val0 = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
